// File: rtl/mandel_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mandel_pixel_sequencer
// Description : Frame-level controller for the Mandelbrot iteration engine.
//               Walks the frame in raster order, starts the engine on each
//               pixel, counts escape iterations up to a latched limit, and
//               emits one (address, count, in-set) result per pixel over a
//               valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module mandel_pixel_sequencer #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              frame_done,
  output logic              eng_init,
  output logic              eng_step,
  output logic [X_W-1:0]    eng_px_x,
  output logic [Y_W-1:0]    eng_px_y,
  input  logic              eng_diverged,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ITER_W-1:0] pix_iter,
  output logic              pix_inset
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_INIT = 3'd1;
  localparam logic [2:0] c_ST_ITER = 3'd2;
  localparam logic [2:0] c_ST_EMIT = 3'd3;
  localparam logic [2:0] c_ST_DONE = 3'd4;

  localparam logic [X_W-1:0] c_X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(V_RES - 1);

  logic [2:0]        r_state;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [ITER_W-1:0] r_iter_cnt;
  logic [ITER_W-1:0] r_limit;
  logic [ITER_W-1:0] r_pix_iter;
  logic              r_pix_inset;

  logic w_in_iter;
  logic w_lim_hit;
  logic w_last_px;

  assign w_in_iter = (r_state == c_ST_ITER);
  assign w_lim_hit = (r_iter_cnt == r_limit);
  assign w_last_px = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

  // Divergence outranks the limit, so a step is only issued when neither ends the pixel.
  assign eng_step   = w_in_iter && !eng_diverged && !w_lim_hit;
  assign eng_init   = (r_state == c_ST_INIT);
  assign pix_valid  = (r_state == c_ST_EMIT);
  assign frame_done = (r_state == c_ST_DONE);
  assign busy       = (r_state != c_ST_IDLE);
  assign eng_px_x   = r_x;
  assign eng_px_y   = r_y;
  assign pix_addr   = r_addr;
  assign pix_iter   = r_pix_iter;
  assign pix_inset  = r_pix_inset;

  // Frame sequencing FSM with pixel coordinates, iteration counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_iter_cnt  <= '0;
      r_limit     <= '0;
      r_pix_iter  <= '0;
      r_pix_inset <= 1'b0;
    end else if (abort && (r_state != c_ST_IDLE)) begin
      // Abort abandons the frame; coordinates are left as-is since the next start clears them.
      r_state <= c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_limit <= max_iter;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_state <= c_ST_INIT;
          end
        end
        c_ST_INIT: begin
          r_iter_cnt <= '0;
          r_state    <= c_ST_ITER;
        end
        c_ST_ITER: begin
          if (eng_diverged) begin
            r_pix_iter  <= r_iter_cnt;
            r_pix_inset <= 1'b0;
            r_state     <= c_ST_EMIT;
          end else if (w_lim_hit) begin
            r_pix_iter  <= r_limit;
            r_pix_inset <= 1'b1;
            r_state     <= c_ST_EMIT;
          end else begin
            r_iter_cnt <= r_iter_cnt + 1'b1;
          end
        end
        c_ST_EMIT: begin
          if (pix_ready) begin
            if (w_last_px) begin
              r_state <= c_ST_DONE;
            end else begin
              if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
              r_addr  <= r_addr + 1'b1;
              r_state <= c_ST_INIT;
            end
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
